// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared 8:1 bit-select path, gating in[sel] onto out.
// Define MUX_RR_MAX_HOLD_EN to pre-empt an owner after MAX_HOLD cycles while others wait.
module mux_rr_arbiter #(
    parameter int NREQ = 8
`ifdef MUX_RR_MAX_HOLD_EN
    , parameter int MAX_HOLD = 4
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] in,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      sel,
    output logic            active,
    output logic            out
);
    typedef enum logic {IDLE, OWN} state_t;
    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d, sel_q, sel_d, nxt_ptr, win;
    logic [NREQ-1:0] grant_q, grant_d, others;
    logic            handoff, preempt;

    // first set bit of r at or after p, wrapping; lowest offset wins
    function automatic logic [2:0] pick(input logic [NREQ-1:0] r, input logic [2:0] p);
        logic [2:0] idx;
        pick = p;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

`ifdef MUX_RR_MAX_HOLD_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q, hold_d;
    assign preempt = (|others) && (hold_q >= HW'(MAX_HOLD - 1));
    always_comb hold_d = (state_q == OWN && !handoff) ? (hold_q == HW'(MAX_HOLD) ? hold_q : hold_q + HW'(1)) : '0;
    always_ff @(posedge clk) hold_q <= rst ? '0 : hold_d;
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        nxt_ptr = sel_q + 3'd1;
        others  = req & ~(NREQ'(1) << sel_q);
        handoff = !req[sel_q] || preempt;
        win     = pick(req, state_q == IDLE ? ptr_q : nxt_ptr);
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = OWN;
                sel_d   = win;
                grant_d = NREQ'(1) << win;
            end
        end else if (handoff) begin
            ptr_d = nxt_ptr;
            if (|others) begin
                sel_d   = win;
                grant_d = NREQ'(1) << win;
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    assign grant  = grant_q;
    assign sel    = sel_q;
    assign active = (state_q == OWN);
    assign out    = active ? in[sel_q] : 1'b0;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed plus random stimulus, reference model feeds a scoreboard queue.
module tb_mux_rr_arbiter;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] req = 8'hFF, in = 8'h00;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       active, out;
`ifdef MUX_RR_MAX_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam int MAX_HOLD = 4;

    typedef struct packed {logic [7:0] g; logic [2:0] s; logic a; logic o;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0;
    int m_owner = -1, m_ptr = 0, m_hold = 0, m_sel = 0;

    mux_rr_arbiter dut (.clk(clk), .rst(rst), .req(req), .in(in), .grant(grant), .sel(sel), .active(active), .out(out));

    always #5 clk = ~clk;

    function automatic int scan(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int o, p, h, s;
        logic [7:0] oth;
        exp_t e;
        o = m_owner; p = m_ptr; h = m_hold; s = m_sel;
        if (rst) begin
            o = -1; p = 0; h = 0; s = 0;
        end else if (o < 0) begin
            if (req != 0) begin o = scan(req, p); h = 0; end
        end else begin
            oth = req & ~(8'd1 << o);
            if (!req[o] || (HOLD_EN && h >= MAX_HOLD - 1 && oth != 0)) begin
                p = (o + 1) % 8;
                o = (oth != 0) ? scan(oth, p) : -1;
                h = 0;
            end else if (h < MAX_HOLD) h++;
        end
        if (o >= 0) s = o;
        e.g = (o >= 0) ? (8'd1 << o) : 8'd0;
        e.s = 3'(s);
        e.a = (o >= 0);
        e.o = (o >= 0) ? in[o] : 1'b0;
        q.push_back(e);
        m_owner <= o; m_ptr <= p; m_hold <= h; m_sel <= s;
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: no expected entry at time %0t", $time);
        end else begin
            e = q.pop_front();
            if ({grant, sel, active, out} !== e) begin
                bad++;
                $display("FAIL arb t=%0t: got grant=%h sel=%0d active=%b out=%b want grant=%h sel=%0d active=%b out=%b",
                         $time, grant, sel, active, out, e.g, e.s, e.a, e.o);
            end
        end
        total++;
        if (!(grant == 8'h00 || $onehot(grant))) begin
            bad++;
            $display("FAIL onehot t=%0t: got grant=%h want zero or one-hot", $time, grant);
        end
    end

    task automatic step(input logic [7:0] r, input logic [7:0] d);
        @(negedge clk);
        req = r;
        in  = d;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(8'hFF, 8'h00);
        step(8'h10, 8'h10);
        step(8'h10, 8'h10);
        step(8'h00, 8'h10);
        step(8'h00, 8'hFF);
        step(8'hFF, 8'hFF);
        repeat (20) step((m_owner >= 0) ? ~(8'd1 << m_owner) : 8'hFF, 8'(($urandom)));
        step(8'h00, 8'h00);
        step(8'h80, 8'h80);
        step(8'hC0, 8'h80);
        step(8'h41, 8'h41);
        step(8'h41, 8'h41);
        step(8'h08, 8'h08);
        step(8'h08, 8'h08);
        rst = 1'b1;
        step(8'h0C, 8'h0C);
        rst = 1'b0;
        repeat (3) step(8'h0C, 8'h04);
        step(8'h00, 8'h00);
        repeat (20) step(8'h03, 8'h01);
        repeat (10) step(8'h01, 8'h01);
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] r;
            r = req ^ ((($urandom % 4) == 0) ? 8'(1 << ($urandom % 8)) : 8'h00);
            if (m_owner >= 0 && ($urandom % 3) == 0) r[m_owner] = 1'b0;
            if (($urandom % 50) == 0) r = 8'h00;
            if (($urandom % 50) == 0) r = 8'hFF;
            rst = (($urandom % 200) == 0);
            step(r, 8'($urandom));
        end
        rst = 1'b0;
        step(8'h00, 8'h00);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
